// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined ARMv8-subset control unit.
package pipe_ctrl_pkg;

  localparam int unsigned OPC_W       = 11;
  localparam int unsigned ALUOP_BITS  = 4;
  localparam int unsigned SIGNOP_BITS = 3;
  localparam int unsigned REG_BITS    = 5;

  localparam logic [REG_BITS-1:0] XZR = '1;

  typedef enum logic [ALUOP_BITS-1:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } aluop_e;

  typedef enum logic [SIGNOP_BITS-1:0] {
    SE_ITYPE  = 3'b000,
    SE_DTYPE  = 3'b001,
    SE_BTYPE  = 3'b010,
    SE_CBTYPE = 3'b011,
    SE_MOVZ   = 3'b100
  } signop_e;

  // Don't-care opcode bits are expressed as a cleared mask bit.
  typedef struct packed {
    logic [OPC_W-1:0] val;
    logic [OPC_W-1:0] mask;
  } opc_pat_t;

  localparam opc_pat_t PAT_ANDREG = '{val: 11'b00001010000, mask: 11'b01111111000};
  localparam opc_pat_t PAT_ORRREG = '{val: 11'b00101010000, mask: 11'b01111111000};
  localparam opc_pat_t PAT_ADDREG = '{val: 11'b00001011000, mask: 11'b01011111000};
  localparam opc_pat_t PAT_SUBREG = '{val: 11'b01001011000, mask: 11'b01011111000};
  localparam opc_pat_t PAT_ADDIMM = '{val: 11'b00010001000, mask: 11'b01011111000};
  localparam opc_pat_t PAT_SUBIMM = '{val: 11'b01010001000, mask: 11'b01011111000};
  localparam opc_pat_t PAT_MOVZ   = '{val: 11'b11010010100, mask: 11'b11111111100};
  localparam opc_pat_t PAT_B      = '{val: 11'b00010100000, mask: 11'b01111100000};
  localparam opc_pat_t PAT_CBZ    = '{val: 11'b00110100000, mask: 11'b01111110000};
  localparam opc_pat_t PAT_LDUR   = '{val: 11'b00111000010, mask: 11'b00111111111};
  localparam opc_pat_t PAT_STUR   = '{val: 11'b00111000000, mask: 11'b00111111111};

  function automatic logic opc_match(input logic [OPC_W-1:0] op, input opc_pat_t pat);
    return ((op ^ pat.val) & pat.mask) == '0;
  endfunction

  typedef struct packed {
    logic                  alusrc;
    logic [ALUOP_BITS-1:0] aluop;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
    logic uncond;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem2reg;
    logic regwrite;
  } wb_ctrl_t;

  typedef struct packed {
    logic                valid;
    ex_ctrl_t            ex;
    mem_ctrl_t           mem;
    wb_ctrl_t            wb;
    logic [REG_BITS-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic                valid;
    mem_ctrl_t           mem;
    wb_ctrl_t            wb;
    logic [REG_BITS-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                valid;
    wb_ctrl_t            wb;
    logic [REG_BITS-1:0] rd;
  } memwb_t;

  localparam idex_t BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: per-stage control bundles plus source usage.
module control_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]       opcode_i,
  output ex_ctrl_t               ex_o,
  output mem_ctrl_t              mem_o,
  output wb_ctrl_t               wb_o,
  output logic                   reg2loc_o,
  output logic [SIGNOP_BITS-1:0] signop_o,
  output logic                   uses_rn_o,
  output logic                   uses_r2_o,
  output logic                   illegal_o
);

  always_comb begin
    ex_o      = '0;
    mem_o     = '0;
    wb_o      = '0;
    reg2loc_o = 1'b0;
    signop_o  = '0;
    uses_rn_o = 1'b1;
    uses_r2_o = 1'b0;
    illegal_o = 1'b0;
    // First match wins, in table order.
    if (opc_match(opcode_i, PAT_ANDREG)) begin
      ex_o.aluop = ALU_AND; wb_o.regwrite = 1'b1; uses_r2_o = 1'b1;
    end else if (opc_match(opcode_i, PAT_ORRREG)) begin
      ex_o.aluop = ALU_ORR; wb_o.regwrite = 1'b1; uses_r2_o = 1'b1;
    end else if (opc_match(opcode_i, PAT_ADDREG)) begin
      ex_o.aluop = ALU_ADD; wb_o.regwrite = 1'b1; uses_r2_o = 1'b1;
    end else if (opc_match(opcode_i, PAT_SUBREG)) begin
      ex_o.aluop = ALU_SUB; wb_o.regwrite = 1'b1; uses_r2_o = 1'b1;
    end else if (opc_match(opcode_i, PAT_ADDIMM)) begin
      ex_o.alusrc = 1'b1; ex_o.aluop = ALU_ADD; signop_o = SE_ITYPE; wb_o.regwrite = 1'b1;
    end else if (opc_match(opcode_i, PAT_SUBIMM)) begin
      ex_o.alusrc = 1'b1; ex_o.aluop = ALU_SUB; signop_o = SE_ITYPE; wb_o.regwrite = 1'b1;
    end else if (opc_match(opcode_i, PAT_MOVZ)) begin
      ex_o.alusrc = 1'b1; ex_o.aluop = ALU_PASSB; signop_o = SE_MOVZ; wb_o.regwrite = 1'b1;
      uses_rn_o = 1'b0;
    end else if (opc_match(opcode_i, PAT_B)) begin
      mem_o.uncond = 1'b1; signop_o = SE_BTYPE; uses_rn_o = 1'b0;
    end else if (opc_match(opcode_i, PAT_CBZ)) begin
      ex_o.aluop = ALU_PASSB; mem_o.branch = 1'b1; reg2loc_o = 1'b1; signop_o = SE_CBTYPE;
      uses_r2_o = 1'b1;
    end else if (opc_match(opcode_i, PAT_LDUR)) begin
      ex_o.alusrc = 1'b1; ex_o.aluop = ALU_ADD; signop_o = SE_DTYPE;
      mem_o.memread = 1'b1; wb_o.mem2reg = 1'b1; wb_o.regwrite = 1'b1;
    end else if (opc_match(opcode_i, PAT_STUR)) begin
      ex_o.alusrc = 1'b1; ex_o.aluop = ALU_ADD; signop_o = SE_DTYPE;
      mem_o.memwrite = 1'b1; reg2loc_o = 1'b1; uses_r2_o = 1'b1;
    end else begin
      illegal_o = 1'b1;
      uses_rn_o = 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_control.sv
// Five-stage pipeline control: decode in ID, stage control registers,
// load-use hazard detection and branch flush.
module pipelined_control
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W  = OPC_W,
  parameter int unsigned ALUOP_W   = ALUOP_BITS,
  parameter int unsigned SIGNOP_W  = SIGNOP_BITS,
  parameter int unsigned REG_W     = REG_BITS,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic                id_valid_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [REG_W-1:0]    rn_i,
  input  logic [REG_W-1:0]    rm_i,
  input  logic [REG_W-1:0]    rd_i,
  input  logic                branch_taken_i,
  output logic                reg2loc_o,
  output logic [SIGNOP_W-1:0] signop_o,
  output logic                ex_alusrc_o,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic                mem_memread_o,
  output logic                mem_memwrite_o,
  output logic                mem_branch_o,
  output logic                mem_uncond_o,
  output logic                wb_mem2reg_o,
  output logic                wb_regwrite_o,
  output logic [REG_W-1:0]    wb_rd_o,
  output logic                stall_o,
  output logic                flush_ifid_o,
  output logic                illegal_o
);

  ex_ctrl_t               dec_ex;
  mem_ctrl_t              dec_mem;
  wb_ctrl_t               dec_wb;
  logic                   dec_reg2loc;
  logic [SIGNOP_BITS-1:0] dec_signop;
  logic                   dec_uses_rn;
  logic                   dec_uses_r2;
  logic                   dec_illegal;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic [REG_W-1:0] src2;
  logic             load_use;
  logic             id_bubble;

  control_decode u_decode (
    .opcode_i  (opcode_i),
    .ex_o      (dec_ex),
    .mem_o     (dec_mem),
    .wb_o      (dec_wb),
    .reg2loc_o (dec_reg2loc),
    .signop_o  (dec_signop),
    .uses_rn_o (dec_uses_rn),
    .uses_r2_o (dec_uses_r2),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    src2     = dec_reg2loc ? rd_i : rm_i;
    load_use = 1'b0;
    if (HAZARD_EN && id_valid_i && idex_q.valid && idex_q.mem.memread && (idex_q.rd != XZR)) begin
      load_use = (dec_uses_rn && (rn_i == idex_q.rd)) || (dec_uses_r2 && (src2 == idex_q.rd));
    end

    // A taken branch discards the ID instruction anyway, so it overrides the stall.
    stall_o      = load_use && !branch_taken_i;
    flush_ifid_o = branch_taken_i;
    illegal_o    = id_valid_i && dec_illegal;
    reg2loc_o    = id_valid_i && dec_reg2loc;
    signop_o     = id_valid_i ? dec_signop : '0;

    id_bubble = !id_valid_i || dec_illegal || load_use || branch_taken_i;
    idex_d    = BUBBLE;
    if (!id_bubble) begin
      idex_d.valid = 1'b1;
      idex_d.ex    = dec_ex;
      idex_d.mem   = dec_mem;
      idex_d.wb    = dec_wb;
      idex_d.rd    = rd_i;
    end

    exmem_d = '0;
    if (!branch_taken_i) begin
      exmem_d = '{valid: idex_q.valid, mem: idex_q.mem, wb: idex_q.wb, rd: idex_q.rd};
    end

    memwb_d = '{valid: exmem_q.valid, wb: exmem_q.wb, rd: exmem_q.rd};
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      idex_q  <= BUBBLE;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_alusrc_o    = idex_q.valid && idex_q.ex.alusrc;
  assign ex_aluop_o     = idex_q.valid ? idex_q.ex.aluop : '0;
  assign mem_memread_o  = exmem_q.valid && exmem_q.mem.memread;
  assign mem_memwrite_o = exmem_q.valid && exmem_q.mem.memwrite;
  assign mem_branch_o   = exmem_q.valid && exmem_q.mem.branch;
  assign mem_uncond_o   = exmem_q.valid && exmem_q.mem.uncond;
  assign wb_mem2reg_o   = memwb_q.valid && memwb_q.wb.mem2reg;
  assign wb_regwrite_o  = memwb_q.valid && memwb_q.wb.regwrite;
  assign wb_rd_o        = memwb_q.valid ? memwb_q.rd : '0;

endmodule

// File: tb/tb_pipelined_control.sv
// Directed, table-driven bench for pipelined_control.
module tb_pipelined_control;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        id_valid_i;
  logic [10:0] opcode_i;
  logic [4:0]  rn_i, rm_i, rd_i;
  logic        branch_taken_i;
  logic        reg2loc_o;
  logic [2:0]  signop_o;
  logic        ex_alusrc_o;
  logic [3:0]  ex_aluop_o;
  logic        mem_memread_o, mem_memwrite_o, mem_branch_o, mem_uncond_o;
  logic        wb_mem2reg_o, wb_regwrite_o;
  logic [4:0]  wb_rd_o;
  logic        stall_o, flush_ifid_o, illegal_o;

  int passed = 0;
  int total  = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  always #5 CLK = ~CLK;

  pipelined_control #(
    .OPCODE_W (11),
    .ALUOP_W  (4),
    .SIGNOP_W (3),
    .REG_W    (5),
    .HAZARD_EN(1'b1)
  ) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .id_valid_i    (id_valid_i),
    .opcode_i      (opcode_i),
    .rn_i          (rn_i),
    .rm_i          (rm_i),
    .rd_i          (rd_i),
    .branch_taken_i(branch_taken_i),
    .reg2loc_o     (reg2loc_o),
    .signop_o      (signop_o),
    .ex_alusrc_o   (ex_alusrc_o),
    .ex_aluop_o    (ex_aluop_o),
    .mem_memread_o (mem_memread_o),
    .mem_memwrite_o(mem_memwrite_o),
    .mem_branch_o  (mem_branch_o),
    .mem_uncond_o  (mem_uncond_o),
    .wb_mem2reg_o  (wb_mem2reg_o),
    .wb_regwrite_o (wb_regwrite_o),
    .wb_rd_o       (wb_rd_o),
    .stall_o       (stall_o),
    .flush_ifid_o  (flush_ifid_o),
    .illegal_o     (illegal_o)
  );

  logic [14:0] regs;
  logic [4:0]  ex_bits;
  logic [3:0]  mem_bits;
  assign ex_bits  = {ex_alusrc_o, ex_aluop_o};
  assign mem_bits = {mem_memread_o, mem_memwrite_o, mem_branch_o, mem_uncond_o};
  assign regs     = {ex_bits, mem_bits, wb_mem2reg_o, wb_regwrite_o, wb_rd_o};

  typedef struct {
    string       name;
    logic [10:0] op;
    logic [4:0]  rd;
    logic        reg2loc;
    logic [2:0]  signop;
    logic        illegal;
    logic [4:0]  ex;    // {alusrc, aluop}
    logic [3:0]  mem;   // {memread, memwrite, branch, uncond}
    logic [1:0]  wb;    // {mem2reg, regwrite}
    logic [4:0]  wbrd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [4:0] rd, input logic bt);
    id_valid_i     = v;
    opcode_i       = op;
    rn_i           = rn;
    rm_i           = rm;
    rd_i           = rd;
    branch_taken_i = bt;
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{"AND",  11'b10001010000, 5'd3,  1'b0, 3'b000, 1'b0, 5'b00000, 4'b0000, 2'b01, 5'd3};
    vt[1]  = '{"ORR",  11'b10101010000, 5'd4,  1'b0, 3'b000, 1'b0, 5'b00001, 4'b0000, 2'b01, 5'd4};
    vt[2]  = '{"ADD",  11'b10001011000, 5'd5,  1'b0, 3'b000, 1'b0, 5'b00010, 4'b0000, 2'b01, 5'd5};
    vt[3]  = '{"SUB",  11'b11001011000, 5'd6,  1'b0, 3'b000, 1'b0, 5'b00110, 4'b0000, 2'b01, 5'd6};
    vt[4]  = '{"ADDI", 11'b10010001000, 5'd7,  1'b0, 3'b000, 1'b0, 5'b10010, 4'b0000, 2'b01, 5'd7};
    vt[5]  = '{"SUBI", 11'b11010001000, 5'd8,  1'b0, 3'b000, 1'b0, 5'b10110, 4'b0000, 2'b01, 5'd8};
    vt[6]  = '{"MOVZ", 11'b11010010100, 5'd9,  1'b0, 3'b100, 1'b0, 5'b10111, 4'b0000, 2'b01, 5'd9};
    vt[7]  = '{"B",    11'b00010100000, 5'd10, 1'b0, 3'b010, 1'b0, 5'b00000, 4'b0001, 2'b00, 5'd10};
    vt[8]  = '{"CBZ",  11'b10110100000, 5'd11, 1'b1, 3'b011, 1'b0, 5'b00111, 4'b0010, 2'b00, 5'd11};
    vt[9]  = '{"LDUR", 11'b11111000010, 5'd12, 1'b0, 3'b001, 1'b0, 5'b10010, 4'b1000, 2'b11, 5'd12};
    vt[10] = '{"STUR", 11'b11111000000, 5'd13, 1'b1, 3'b001, 1'b0, 5'b10010, 4'b0100, 2'b00, 5'd13};
    vt[11] = '{"ILL",  11'b00000000000, 5'd14, 1'b0, 3'b000, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd0};

    resetl = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    #1 resetl = 1'b0;
    #3 chk("reset_async_regs", 32'(regs), 32'd0);
    @(posedge CLK);
    next_cycle();
    resetl = 1'b1;
    @(negedge CLK);
    chk("reset_regs", 32'(regs), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      drive(1'b1, vt[i].op, 5'd1, 5'd2, vt[i].rd, 1'b0);
      @(negedge CLK);
      chk({vt[i].name, ".reg2loc"}, 32'(reg2loc_o), 32'(vt[i].reg2loc));
      chk({vt[i].name, ".signop"},  32'(signop_o),  32'(vt[i].signop));
      chk({vt[i].name, ".illegal"}, 32'(illegal_o), 32'(vt[i].illegal));
      chk({vt[i].name, ".stall"},   32'(stall_o),   32'd0);
      next_cycle();
      drive(1'b0, '0, '0, '0, '0, 1'b0);
      @(negedge CLK);
      chk({vt[i].name, ".ex"},          32'(ex_bits),   32'(vt[i].ex));
      chk({vt[i].name, ".illegal_end"}, 32'(illegal_o), 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      chk({vt[i].name, ".mem"}, 32'(mem_bits), 32'(vt[i].mem));
      @(posedge CLK);
      @(negedge CLK);
      chk({vt[i].name, ".wb"},   32'({wb_mem2reg_o, wb_regwrite_o}), 32'(vt[i].wb));
      chk({vt[i].name, ".wbrd"}, 32'(wb_rd_o), 32'(vt[i].wbrd));
    end

    // Load-use: LDUR X2 then ADD X3,X2,X4
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    @(negedge CLK); chk("lu.ldur_nostall", 32'(stall_o), 32'd0);
    next_cycle(); drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    @(negedge CLK);
    chk("lu.stall", 32'(stall_o), 32'd1);
    chk("lu.ex_ldur", 32'(ex_bits), 32'b10010);
    next_cycle();
    @(negedge CLK);
    chk("lu.stall_once", 32'(stall_o), 32'd0);
    chk("lu.ex_bubble", 32'(ex_bits), 32'd0);
    chk("lu.mem_ldur", 32'(mem_memread_o), 32'd1);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge CLK);
    chk("lu.ex_add_late", 32'(ex_bits), 32'b00010);
    chk("lu.wb_ldur", 32'({wb_mem2reg_o, wb_regwrite_o, wb_rd_o}), 32'({2'b11, 5'd2}));

    // Load-use via STUR Rt, and a non-matching consumer
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0);
    next_cycle(); drive(1'b1, OP_STUR, 5'd1, 5'd0, 5'd5, 1'b0);
    @(negedge CLK); chk("lu.stur_rt", 32'(stall_o), 32'd1);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    next_cycle(); drive(1'b1, OP_ADD, 5'd1, 5'd4, 5'd2, 1'b0);
    @(negedge CLK); chk("lu.no_match", 32'(stall_o), 32'd0);

    // XZR exemption
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd31, 1'b0);
    next_cycle(); drive(1'b1, OP_ADD, 5'd31, 5'd31, 5'd3, 1'b0);
    @(negedge CLK); chk("xzr.nostall", 32'(stall_o), 32'd0);

    // Branch flush while load-use hazard present
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    next_cycle(); drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 1'b1);
    @(negedge CLK);
    chk("br.flush", 32'(flush_ifid_o), 32'd1);
    chk("br.stall_forced0", 32'(stall_o), 32'd0);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge CLK);
    chk("br.ex_zero", 32'(ex_bits), 32'd0);
    chk("br.mem_zero", 32'(mem_bits), 32'd0);
    chk("br.flush_end", 32'(flush_ifid_o), 32'd0);

    // Back-to-back taken branches
    next_cycle(); drive(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd4, 1'b1);
    @(negedge CLK); chk("bb.flush1", 32'(flush_ifid_o), 32'd1);
    next_cycle(); drive(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd5, 1'b1);
    @(negedge CLK);
    chk("bb.flush2", 32'(flush_ifid_o), 32'd1);
    chk("bb.ex1_zero", 32'(ex_bits), 32'd0);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge CLK); chk("bb.ex2_zero", 32'(ex_bits), 32'd0);

    // Reset mid-stream: STUR in MEM, LDUR X2 in EX
    next_cycle(); drive(1'b1, OP_STUR, 5'd1, 5'd0, 5'd6, 1'b0);
    next_cycle(); drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge CLK);
    chk("rst.pre_memwrite", 32'(mem_memwrite_o), 32'd1);
    #2 resetl = 1'b0;
    #1;
    chk("rst.memwrite_async", 32'(mem_memwrite_o), 32'd0);
    chk("rst.regs_async", 32'(regs), 32'd0);
    next_cycle();
    next_cycle();
    resetl = 1'b1;
    @(negedge CLK); chk("rst.regs_held", 32'(regs), 32'd0);
    next_cycle(); drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3, 1'b0);
    @(negedge CLK); chk("rst.no_residual_stall", 32'(stall_o), 32'd0);
    next_cycle(); drive(1'b0, '0, '0, '0, '0, 1'b0);
    @(negedge CLK); chk("rst.ex_add", 32'(ex_bits), 32'b00010);
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    chk("rst.wb_add", 32'({wb_mem2reg_o, wb_regwrite_o, wb_rd_o}), 32'({2'b01, 5'd3}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
